avgpool_seq: RTL and testbench



---
 rtl/avgpool_seq_if.sv | 43 ++++
 rtl/avgpool_seq.sv | 193 +++++++++++++++++++
 tb/tb_avgpool_seq.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avgpool_seq_if.sv
// Operand/result bundle between the pooling sequencer and its environment
// (pooling buffer, sacc accumulator/divider, downstream consumer).
interface avgpool_seq_if #(
  parameter int unsigned WLEN_W = 8
);
  localparam int unsigned DATA_W = 16;

  logic              start;
  logic [WLEN_W-1:0] win_len;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] tmp_sum;
  logic [DATA_W-1:0] acc_data;
  logic              data_ready;
  logic              acc_rfd;
  logic [DATA_W-1:0] sum_in;
  logic              sum_ready;
  logic              div_en;
  logic [DATA_W-1:0] pool_in;
  logic              pool_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;

  // Sequencer side
  modport slave (
    input  start, win_len, in_data, in_valid, acc_rfd, sum_in, sum_ready,
           pool_in, pool_ready, out_ready,
    output in_ready, tmp_sum, acc_data, data_ready, div_en, out_data,
           out_valid, busy, err
  );

  // Environment side
  modport master (
    output start, win_len, in_data, in_valid, acc_rfd, sum_in, sum_ready,
           pool_in, pool_ready, out_ready,
    input  in_ready, tmp_sum, acc_data, data_ready, div_en, out_data,
           out_valid, busy, err
  );
endinterface

// File: rtl/avgpool_seq.sv
// Serial operand sequencer for the FP16 average-pooling accumulator/divider.
// Define AVGPOOL_TIMEOUT_EN to add a watchdog that aborts stalled waits.
module avgpool_seq #(
  parameter int unsigned WLEN_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  avgpool_seq_if.slave bus
);
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_SUM,
    S_DIV,
    S_WAIT_DIV,
    S_OUT
  } state_t;

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("avgpool_seq: TIMEOUT must be nonzero");
  end

  state_t            state, state_d;
  logic [WLEN_W-1:0] len_q, len_d;
  logic [WLEN_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] tmp_sum_q, tmp_sum_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              data_ready_q, data_ready_d;
  logic              div_en_q, div_en_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q;
  logic              take;

  assign take = (state == S_FETCH) && bus.in_valid && bus.acc_rfd;

`ifdef AVGPOOL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
`endif

  // Next-state and next-register values
  always_comb begin
    state_d      = state;
    len_d        = len_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    tmp_sum_d    = tmp_sum_q;
    acc_d        = acc_q;
    out_d        = out_q;
    data_ready_d = 1'b0;
    div_en_d     = 1'b0;
    out_valid_d  = out_valid_q;
`ifdef AVGPOOL_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (bus.start && (bus.win_len != '0)) begin
          len_d   = bus.win_len;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (take) begin
          acc_d        = bus.in_data;
          tmp_sum_d    = sum_q;
          data_ready_d = 1'b1;
          state_d      = S_WAIT_SUM;
`ifdef AVGPOOL_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end
      S_WAIT_SUM: begin
        // One element in flight: the next operand needs this sum fed back
        if (bus.sum_ready) begin
          sum_d   = bus.sum_in;
          cnt_d   = WLEN_W'(cnt_q + 1'b1);
          state_d = (WLEN_W'(cnt_q + 1'b1) == len_q) ? S_DIV : S_FETCH;
        end
`ifdef AVGPOOL_TIMEOUT_EN
        else if (wd_expired) begin
          err_d   = 1'b1;
          sum_d   = '0;
          state_d = S_IDLE;
        end else begin
          wd_d = WD_W'(wd_q + 1'b1);
        end
`endif
      end
      S_DIV: begin
        acc_d    = sum_q;
        div_en_d = 1'b1;
        state_d  = S_WAIT_DIV;
`ifdef AVGPOOL_TIMEOUT_EN
        wd_d     = '0;
`endif
      end
      S_WAIT_DIV: begin
        // acc_data stays on the dividend; the divider samples it late
        if (bus.pool_ready) begin
          out_d       = bus.pool_in;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
`ifdef AVGPOOL_TIMEOUT_EN
        else if (wd_expired) begin
          err_d   = 1'b1;
          sum_d   = '0;
          state_d = S_IDLE;
        end else begin
          wd_d = WD_W'(wd_q + 1'b1);
        end
`endif
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      tmp_sum_q    <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      data_ready_q <= 1'b0;
      div_en_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      tmp_sum_q    <= tmp_sum_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      data_ready_q <= data_ready_d;
      div_en_q     <= div_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

`ifdef AVGPOOL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // in_ready follows the accumulator's readiness combinationally in FETCH
  assign bus.in_ready   = (state == S_FETCH) && bus.acc_rfd;
  assign bus.tmp_sum    = tmp_sum_q;
  assign bus.acc_data   = acc_q;
  assign bus.data_ready = data_ready_q;
  assign bus.div_en     = div_en_q;
  assign bus.out_data   = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_avgpool_seq.sv
// Scoreboard bench for avgpool_seq: random windows against a prefix-sum model,
// with accumulator/divider responders returning pre-chosen results.
module tb_avgpool_seq;
  localparam int unsigned WLEN_W  = 8;
  localparam int unsigned TIMEOUT = 64;

  typedef struct packed {
    logic [15:0] tmp;
    logic [15:0] dat;
  } acc_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  avgpool_seq_if #(.WLEN_W(WLEN_W)) bus ();

  avgpool_seq #(.WLEN_W(WLEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int epoch  = 0;
  bit acc_hold = 1'b0;

  acc_exp_t    exp_acc_q[$];
  logic [15:0] exp_div_q[$];
  logic [15:0] exp_dvd_q[$];
  logic [15:0] exp_out_q[$];
  logic [15:0] rsp_q[$];
  logic [15:0] pool_q[$];

  logic [15:0] el[$];
  logic [15:0] rs[$];
  logic [15:0] pv;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got no/unexpected event, expected the opposite", name);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    exp_acc_q.delete();
    exp_div_q.delete();
    exp_dvd_q.delete();
    exp_out_q.delete();
    rsp_q.delete();
    pool_q.delete();
  endtask

  task automatic pulse_start(input int n);
    bus.start   = 1'b1;
    bus.win_len = WLEN_W'(n);
    tick();
    bus.start   = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an operand or result
  initial begin
    logic        prev_hold;
    logic [15:0] prev_out;
    acc_exp_t    e;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("out_valid_hold", bus.out_valid, 1);
          chk("out_data_hold", bus.out_data, prev_out);
        end
        if (bus.data_ready) begin
          if (exp_acc_q.size() == 0) fail("unexpected_data_ready");
          else begin
            e = exp_acc_q.pop_front();
            chk("tmp_sum", bus.tmp_sum, e.tmp);
            chk("acc_data_elem", bus.acc_data, e.dat);
          end
        end
        if (bus.div_en) begin
          if (exp_div_q.size() == 0) fail("unexpected_div_en");
          else chk("acc_data_div", bus.acc_data, exp_div_q.pop_front());
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_out_q.size() == 0) fail("unexpected_out");
          else chk("out_data", bus.out_data, exp_out_q.pop_front());
        end
`ifndef AVGPOOL_TIMEOUT_EN
        chk("err_tied_low", bus.err, 0);
`endif
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_out  = bus.out_data;
      end
    end
  end

  // Accumulator model: answers each data_ready with the next queued sum
  initial begin
    int          ep;
    int          lat;
    logic [15:0] r;
    bus.sum_ready = 1'b0;
    bus.sum_in    = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.data_ready && !acc_hold) begin
        ep  = epoch;
        r   = (rsp_q.size() != 0) ? rsp_q.pop_front() : 16'h0000;
        lat = $urandom_range(1, 4);
        repeat (lat) @(posedge clk);
        #1;
        if (ep == epoch) begin
          bus.sum_in    = r;
          bus.sum_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.sum_ready = 1'b0;
          bus.sum_in    = 16'($urandom);
        end
      end
    end
  end

  // Divider model: takes the dividend one cycle after div_en
  initial begin
    int          ep;
    int          lat;
    logic [15:0] q;
    bus.pool_ready = 1'b0;
    bus.pool_in    = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.div_en) begin
        ep = epoch;
        @(negedge clk);
        if (exp_dvd_q.size() == 0) fail("unexpected_dividend");
        else chk("dividend_held", bus.acc_data, exp_dvd_q.pop_front());
        q   = (pool_q.size() != 0) ? pool_q.pop_front() : 16'h0000;
        lat = $urandom_range(0, 4);
        repeat (lat + 1) @(posedge clk);
        #1;
        if (ep == epoch) begin
          bus.pool_in    = q;
          bus.pool_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.pool_ready = 1'b0;
        end
      end
    end
  end

  // One window: expected operands are the prefix of accumulator results
  task automatic do_window(input bit bp, input bit stall, input int abort_at);
    int          n;
    logic [15:0] prev;
    acc_exp_t    e;
    int          guard;
    int          held;
    bit          got;
    n    = el.size();
    prev = 16'h0000;
    for (int k = 0; k < n; k++) begin
      e.tmp = prev;
      e.dat = el[k];
      exp_acc_q.push_back(e);
      rsp_q.push_back(rs[k]);
      prev = rs[k];
    end
    if (abort_at < 0) begin
      exp_div_q.push_back(prev);
      exp_dvd_q.push_back(prev);
      exp_out_q.push_back(pv);
      pool_q.push_back(pv);
    end
    pulse_start(n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = el[k];
      if (bp && k == 0) begin
        for (int c = 0; c < 5; c++) begin
          bus.acc_rfd = 1'b0;
          @(negedge clk);
          chk("in_ready_backpressure", bus.in_ready, 0);
          tick();
        end
      end
      got   = 1'b0;
      guard = 0;
      while (!got && guard < 200) begin
        bus.acc_rfd = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        got = bus.in_valid && bus.in_ready;
        tick();
        guard++;
      end
      if (!got) fail("in_handshake_timeout");
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      if (k + 1 == abort_at) begin
        @(negedge clk);
        chk("data_ready_before_reset", bus.data_ready, 1);
        #1;
        rst = 1'b1;
        epoch++;
        flush_all();
        @(negedge clk);
        chk("rst_tmp_sum", bus.tmp_sum, 0);
        chk("rst_acc_data", bus.acc_data, 0);
        chk("rst_data_ready", bus.data_ready, 0);
        chk("rst_div_en", bus.div_en, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        return;
      end
    end
    got   = 1'b0;
    guard = 0;
    held  = 0;
    while (!got && guard < 500) begin
      if (stall) bus.out_ready = (held >= 10);
      else       bus.out_ready = 1'($urandom_range(0, 1));
      if (stall && (held == 4 || held == 10)) begin
        bus.start   = 1'b1;
        bus.win_len = WLEN_W'(2);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      got = bus.out_valid && bus.out_ready;
      if (bus.out_valid) held++;
      if (stall && bus.out_valid && !got) chk("busy_in_out", bus.busy, 1);
      tick();
      guard++;
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    if (!got) fail("out_timeout");
    @(negedge clk);
    chk("busy_after_out", bus.busy, 0);
    chk("out_valid_after_out", bus.out_valid, 0);
    tick();
  endtask

  task automatic fill_random(input int n);
    el.delete();
    rs.delete();
    for (int k = 0; k < n; k++) begin
      el.push_back(16'($urandom));
      rs.push_back(16'($urandom));
    end
    pv = 16'($urandom);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.win_len   = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.acc_rfd   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_tmp_sum", bus.tmp_sum, 0);
    chk("reset_acc_data", bus.acc_data, 0);
    chk("reset_data_ready", bus.data_ready, 0);
    chk("reset_div_en", bus.div_en, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Basic three-element window
    el = '{16'h3C00, 16'h3C00, 16'h3C00};
    rs = '{16'h3C00, 16'h4000, 16'h4200};
    pv = 16'h3C00;
    do_window(1'b0, 1'b0, -1);

    // Zero-length start is ignored
    pulse_start(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("win_len0_busy", bus.busy, 0);
      tick();
    end

    // Single-element window
    el = '{16'h4500};
    rs = '{16'h4500};
    pv = 16'h4500;
    do_window(1'b0, 1'b0, -1);

    // Accumulator backpressure, then output stall with ignored starts
    fill_random(4);
    do_window(1'b1, 1'b0, -1);
    fill_random(3);
    do_window(1'b0, 1'b1, -1);

    // Reset while the third of four elements is in flight
    fill_random(4);
    do_window(1'b0, 1'b0, 3);
    fill_random(2);
    do_window(1'b0, 1'b0, -1);

`ifdef AVGPOOL_TIMEOUT_EN
    begin
      acc_exp_t e;
      int       k;
      acc_hold = 1'b1;
      e.tmp    = 16'h0000;
      e.dat    = 16'h1234;
      exp_acc_q.push_back(e);
      pulse_start(1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      bus.acc_rfd  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("wd_entry_data_ready", bus.data_ready, 1);
      k = 0;
      while (k < 200) begin
        @(negedge clk);
        k++;
        if (bus.err) break;
        chk("wd_no_out_valid", bus.out_valid, 0);
      end
      chk("wd_err_cycle", k, TIMEOUT);
      chk("wd_err_out_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("wd_err_pulse_len", bus.err, 0);
      chk("wd_busy_after", bus.busy, 0);
      acc_hold = 1'b0;
      @(posedge clk);
      #1;
    end
`endif

    // Random windows
    for (int w = 0; w < 20; w++) begin
      fill_random($urandom_range(1, 12));
      do_window(1'($urandom_range(0, 1)), 1'b0, -1);
    end
    fill_random(40);
    do_window(1'b0, 1'b0, -1);

    repeat (5) tick();
    chk("sb_acc_drained", exp_acc_q.size(), 0);
    chk("sb_div_drained", exp_div_q.size(), 0);
    chk("sb_out_drained", exp_out_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
